// File: rtl/axi_lite_prewrapper_bridge_if.sv
// AXI4-Lite channel bundle between the host interconnect and the prewrapper bridge.
// The bridge takes the slave modport; the host (or a bench) takes the master modport.
interface axi_lite_prewrapper_bridge_if;
   logic [31:0] s_axi_awaddr;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [31:0] s_axi_araddr;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;

   modport slave (
      input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
             s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
      output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
             s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );

   modport master (
      output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
             s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
      input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
             s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );
endinterface

// File: rtl/axi_lite_prewrapper_bridge.sv
// AXI4-Lite slave that serialises host writes/reads onto the prewrapper's flat
// register port, one access at a time, parking both addresses on an idle value.
module axi_lite_prewrapper_bridge #(
   parameter logic [31:0] p_addr_limit = 32'h0000_0100,
   parameter logic [31:0] p_idle_addr  = 32'hFFFF_FFFF
) (
   input  logic                               clk,
   input  logic                               reset,
   axi_lite_prewrapper_bridge_if.slave        s_axi,
   output logic [31:0]                        axi_wr_addr,
   output logic [31:0]                        axi_wr_msg,
   output logic [31:0]                        axi_rd_addr,
   input  logic [31:0]                        axi_rd_msg
);

   typedef enum logic [2:0] {
      IDLE, WR_ISSUE, WR_RESP, RD_ADDR, RD_CAPT, RD_RESP
   } state_t;

   typedef struct packed {
      logic [29:0] idx;
      logic [31:0] data;
   } wr_req_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   state_t      state, state_d;

   // Channel capture registers
   logic        aw_held, w_held, ar_held;
   logic [29:0] aw_idx, ar_idx;
   logic [31:0] w_data;
   logic [3:0]  w_strb;

   // Granted transaction, kept apart from the capture registers so that new
   // beats accepted mid-flight cannot disturb the access being issued.
   wr_req_t     wr_req;
   logic [29:0] rd_idx;

   logic        last_grant_rd;
   logic        grant_wr, grant_rd;
   logic        aw_fire, w_fire, ar_fire;
   logic        wr_bad_strb, wr_bad_addr, rd_bad_addr;

   logic [1:0]  bresp_q, rresp_q;
   logic [31:0] rdata_q;

   logic        unused_addr_lsbs;

   assign unused_addr_lsbs = ^{s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0]};

   assign s_axi.s_axi_awready = !reset && !aw_held;
   assign s_axi.s_axi_wready  = !reset && !w_held;
   assign s_axi.s_axi_arready = !reset && !ar_held;

   assign aw_fire = s_axi.s_axi_awvalid && s_axi.s_axi_awready;
   assign w_fire  = s_axi.s_axi_wvalid  && s_axi.s_axi_wready;
   assign ar_fire = s_axi.s_axi_arvalid && s_axi.s_axi_arready;

   assign wr_bad_strb = (w_strb != 4'hF);
   assign wr_bad_addr = ({2'b00, aw_idx} >= p_addr_limit);
   assign rd_bad_addr = ({2'b00, ar_idx} >= p_addr_limit);

   assign s_axi.s_axi_bvalid = (state == WR_RESP);
   assign s_axi.s_axi_rvalid = (state == RD_RESP);
   assign s_axi.s_axi_bresp  = bresp_q;
   assign s_axi.s_axi_rresp  = rresp_q;
   assign s_axi.s_axi_rdata  = rdata_q;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d     = state;
      grant_wr    = 1'b0;
      grant_rd    = 1'b0;
      axi_wr_addr = p_idle_addr;
      axi_wr_msg  = 32'h0;
      axi_rd_addr = p_idle_addr;
      case (state)
         IDLE: begin
            // On a tie, serve the opposite of whatever was granted last.
            if (aw_held && w_held && (!ar_held || last_grant_rd)) grant_wr = 1'b1;
            else if (ar_held)                                     grant_rd = 1'b1;
            if (grant_wr)      state_d = (wr_bad_strb || wr_bad_addr) ? WR_RESP : WR_ISSUE;
            else if (grant_rd) state_d = rd_bad_addr ? RD_RESP : RD_ADDR;
         end
         WR_ISSUE: begin
            axi_wr_addr = {2'b00, wr_req.idx};
            axi_wr_msg  = wr_req.data;
            state_d     = WR_RESP;
         end
         WR_RESP: if (s_axi.s_axi_bready) state_d = IDLE;
         RD_ADDR: begin
            axi_rd_addr = {2'b00, rd_idx};
            state_d     = RD_CAPT;
         end
         RD_CAPT: begin
            axi_rd_addr = {2'b00, rd_idx};
            state_d     = RD_RESP;
         end
         RD_RESP: if (s_axi.s_axi_rready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         ar_held       <= 1'b0;
         aw_idx        <= '0;
         ar_idx        <= '0;
         w_data        <= '0;
         w_strb        <= '0;
         wr_req        <= '0;
         rd_idx        <= '0;
         last_grant_rd <= 1'b1;
         bresp_q       <= RESP_OKAY;
         rresp_q       <= RESP_OKAY;
         rdata_q       <= '0;
      end else begin
         if (aw_fire) begin
            aw_held <= 1'b1;
            aw_idx  <= s_axi.s_axi_awaddr[31:2];
         end
         if (w_fire) begin
            w_held <= 1'b1;
            w_data <= s_axi.s_axi_wdata;
            w_strb <= s_axi.s_axi_wstrb;
         end
         if (ar_fire) begin
            ar_held <= 1'b1;
            ar_idx  <= s_axi.s_axi_araddr[31:2];
         end

         if (grant_wr) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            last_grant_rd <= 1'b0;
            wr_req.idx    <= aw_idx;
            wr_req.data   <= w_data;
            if (wr_bad_strb)      bresp_q <= RESP_SLVERR;
            else if (wr_bad_addr) bresp_q <= RESP_DECERR;
            else                  bresp_q <= RESP_OKAY;
         end

         if (grant_rd) begin
            ar_held       <= 1'b0;
            last_grant_rd <= 1'b1;
            rd_idx        <= ar_idx;
            rresp_q       <= rd_bad_addr ? RESP_DECERR : RESP_OKAY;
            if (rd_bad_addr) rdata_q <= '0;
         end

         if (state == RD_CAPT) rdata_q <= axi_rd_msg;
      end
   end

endmodule

// File: tb/tb_axi_lite_prewrapper_bridge.sv
// Directed bench for axi_lite_prewrapper_bridge: expected prewrapper accesses and
// B/R responses are queued as stimulus is driven and checked as the DUT emits them.
module tb_axi_lite_prewrapper_bridge;
   localparam logic [31:0] P_IDLE  = 32'hFFFF_FFFF;
   localparam logic [31:0] P_LIMIT = 32'h0000_0100;

   typedef struct {
      logic [31:0] idx;
      logic [31:0] data;
   } wr_exp_t;

   typedef struct {
      logic [31:0] idx;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic        mapped;
   } rd_exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] axi_wr_addr, axi_wr_msg, axi_rd_addr, axi_rd_msg;

   axi_lite_prewrapper_bridge_if bus ();

   axi_lite_prewrapper_bridge dut (
      .clk         (clk),
      .reset       (reset),
      .s_axi       (bus),
      .axi_wr_addr (axi_wr_addr),
      .axi_wr_msg  (axi_wr_msg),
      .axi_rd_addr (axi_rd_addr),
      .axi_rd_msg  (axi_rd_msg)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_model(input logic [31:0] idx);
      return (idx == 32'd3) ? 32'h1234_5678 : (idx ^ 32'hC0DE_0000);
   endfunction

   assign axi_rd_msg = mem_model(axi_rd_addr);

   wr_exp_t     exp_wr[$];
   rd_exp_t     exp_r[$];
   logic [1:0]  exp_b[$];
   int          order_log[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_issues = 0, wr_issue_cyc = -1, rd_first_cyc = -1, rd_last_cyc = -1;
   int b_rise_cyc = -1, r_rise_cyc = -1;
   int aw_hs_cyc = -1, w_hs_cyc = -1, ar_hs_cyc = -1;
   bit aw_hs, w_hs, ar_hs, rd_prev, bv_prev, rv_prev;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic timeout_fail(input string tag);
      checks++;
      errors++;
      $error("FAIL %s observed=timeout expected=completion", tag);
   endtask

   // One clock cycle: sample and score the DUT at the falling edge, then
   // return just after the next rising edge so the caller can drive inputs.
   task automatic tick();
      wr_exp_t    we;
      logic [1:0] bdrop;
      rd_exp_t    rdrop;
      @(negedge clk);
      cyc++;
      aw_hs = (bus.s_axi_awvalid === 1'b1) && (bus.s_axi_awready === 1'b1);
      w_hs  = (bus.s_axi_wvalid  === 1'b1) && (bus.s_axi_wready  === 1'b1);
      ar_hs = (bus.s_axi_arvalid === 1'b1) && (bus.s_axi_arready === 1'b1);
      if (aw_hs) aw_hs_cyc = cyc;
      if (w_hs)  w_hs_cyc  = cyc;
      if (ar_hs) ar_hs_cyc = cyc;

      if (axi_wr_addr !== P_IDLE || axi_wr_msg !== 32'h0) begin
         wr_issues++;
         wr_issue_cyc = cyc;
         order_log.push_back(1);
         if (exp_wr.size() == 0) begin
            chk("spurious_wr_addr", axi_wr_addr, P_IDLE);
            chk("spurious_wr_msg", axi_wr_msg, 32'h0);
         end else begin
            we = exp_wr.pop_front();
            chk("wr_addr", axi_wr_addr, we.idx);
            chk("wr_msg", axi_wr_msg, we.data);
         end
      end

      if (axi_rd_addr !== P_IDLE) begin
         if (!rd_prev) begin
            rd_first_cyc = cyc;
            order_log.push_back(2);
         end
         rd_last_cyc = cyc;
         if (exp_r.size() == 0 || !exp_r[0].mapped) chk("spurious_rd_addr", axi_rd_addr, P_IDLE);
         else                                        chk("rd_addr", axi_rd_addr, exp_r[0].idx);
      end
      rd_prev = (axi_rd_addr !== P_IDLE);

      if (bus.s_axi_bvalid === 1'b1) begin
         if (!bv_prev) b_rise_cyc = cyc;
         if (exp_b.size() == 0) chk("spurious_bvalid", 32'(bus.s_axi_bvalid), 32'h0);
         else begin
            chk("bresp", 32'(bus.s_axi_bresp), 32'(exp_b[0]));
            if (bus.s_axi_bready === 1'b1) bdrop = exp_b.pop_front();
         end
      end
      bv_prev = (bus.s_axi_bvalid === 1'b1);

      if (bus.s_axi_rvalid === 1'b1) begin
         if (!rv_prev) r_rise_cyc = cyc;
         if (exp_r.size() == 0) chk("spurious_rvalid", 32'(bus.s_axi_rvalid), 32'h0);
         else begin
            chk("rresp", 32'(bus.s_axi_rresp), 32'(exp_r[0].rresp));
            chk("rdata", bus.s_axi_rdata, exp_r[0].rdata);
            if (bus.s_axi_rready === 1'b1) rdrop = exp_r.pop_front();
         end
      end
      rv_prev = (bus.s_axi_rvalid === 1'b1);

      @(posedge clk);
      #1;
   endtask

   task automatic exp_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic [31:0] idx;
      idx = addr >> 2;
      if (strb != 4'hF)        exp_b.push_back(2'b10);
      else if (idx >= P_LIMIT) exp_b.push_back(2'b11);
      else begin
         exp_wr.push_back('{idx: idx, data: data});
         exp_b.push_back(2'b00);
      end
   endtask

   task automatic exp_read(input logic [31:0] addr);
      logic [31:0] idx;
      idx = addr >> 2;
      if (idx >= P_LIMIT) exp_r.push_back('{idx: idx, rdata: 32'h0, rresp: 2'b11, mapped: 1'b0});
      else                exp_r.push_back('{idx: idx, rdata: mem_model(idx), rresp: 2'b00, mapped: 1'b1});
   endtask

   task automatic drive(input bit do_aw, input logic [31:0] awaddr,
                        input bit do_w, input logic [31:0] wdata, input logic [3:0] wstrb,
                        input bit do_ar, input logic [31:0] araddr);
      bus.s_axi_awvalid = do_aw;
      bus.s_axi_awaddr  = awaddr;
      bus.s_axi_wvalid  = do_w;
      bus.s_axi_wdata   = wdata;
      bus.s_axi_wstrb   = wstrb;
      bus.s_axi_arvalid = do_ar;
      bus.s_axi_araddr  = araddr;
      for (int i = 0; i < 40 && (bus.s_axi_awvalid || bus.s_axi_wvalid || bus.s_axi_arvalid); i++) begin
         tick();
         if (aw_hs) bus.s_axi_awvalid = 1'b0;
         if (w_hs)  bus.s_axi_wvalid  = 1'b0;
         if (ar_hs) bus.s_axi_arvalid = 1'b0;
      end
      if (bus.s_axi_awvalid || bus.s_axi_wvalid || bus.s_axi_arvalid) begin
         timeout_fail("drive_handshake");
         bus.s_axi_awvalid = 1'b0;
         bus.s_axi_wvalid  = 1'b0;
         bus.s_axi_arvalid = 1'b0;
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 60 && (exp_wr.size() + exp_b.size() + exp_r.size() != 0); i++) tick();
      if (exp_wr.size() + exp_b.size() + exp_r.size() != 0) begin
         timeout_fail("wait_done");
         exp_wr.delete();
         exp_b.delete();
         exp_r.delete();
      end
      tick();
   endtask

   initial begin
      int t, n0, saved;
      bus.s_axi_awvalid = 1'b0; bus.s_axi_awaddr = '0;
      bus.s_axi_wvalid  = 1'b0; bus.s_axi_wdata  = '0; bus.s_axi_wstrb = '0;
      bus.s_axi_arvalid = 1'b0; bus.s_axi_araddr = '0;
      bus.s_axi_bready  = 1'b1; bus.s_axi_rready = 1'b1;
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;

      chk("rst_awready", 32'(bus.s_axi_awready), 32'h0);
      chk("rst_wready",  32'(bus.s_axi_wready),  32'h0);
      chk("rst_arready", 32'(bus.s_axi_arready), 32'h0);
      chk("rst_bvalid",  32'(bus.s_axi_bvalid),  32'h0);
      chk("rst_rvalid",  32'(bus.s_axi_rvalid),  32'h0);
      chk("rst_bresp",   32'(bus.s_axi_bresp),   32'h0);
      chk("rst_rresp",   32'(bus.s_axi_rresp),   32'h0);
      chk("rst_rdata",   bus.s_axi_rdata,        32'h0);
      chk("rst_wr_addr", axi_wr_addr, P_IDLE);
      chk("rst_wr_msg",  axi_wr_msg,  32'h0);
      chk("rst_rd_addr", axi_rd_addr, P_IDLE);
      reset = 1'b0;
      #1;
      chk("post_rst_awready", 32'(bus.s_axi_awready), 32'h1);
      tick();

      // Basic write, AW and W together
      exp_write(32'h8, 32'hDEAD_BEEF, 4'hF);
      drive(1, 32'h8, 1, 32'hDEAD_BEEF, 4'hF, 0, 32'h0);
      t = aw_hs_cyc;
      chk("wr_aw_w_same_cycle", 32'(w_hs_cyc), 32'(t));
      wait_done();
      chk("wr_issue_cycle", 32'(wr_issue_cyc), 32'(t + 2));
      chk("wr_bvalid_cycle", 32'(b_rise_cyc), 32'(t + 3));
      chk("wr_issue_count", 32'(wr_issues), 32'd1);

      // Read with back-pressure on R
      bus.s_axi_rready = 1'b0;
      exp_read(32'hC);
      drive(0, 32'h0, 0, 32'h0, 4'h0, 1, 32'hC);
      t = ar_hs_cyc;
      repeat (8) tick();
      chk("rd_stall_rvalid", 32'(bus.s_axi_rvalid), 32'h1);
      bus.s_axi_rready = 1'b1;
      wait_done();
      chk("rd_addr_first", 32'(rd_first_cyc), 32'(t + 2));
      chk("rd_addr_last", 32'(rd_last_cyc), 32'(t + 3));
      chk("rd_rvalid_cycle", 32'(r_rise_cyc), 32'(t + 4));

      // Arbitration: last grant was a read, so the first tie goes to the write;
      // the second write then ties with the waiting read, which must win.
      order_log.delete();
      exp_write(32'h20, 32'hA1A1_0001, 4'hF);
      exp_read(32'h14);
      exp_write(32'h24, 32'hA2A2_0002, 4'hF);
      drive(1, 32'h20, 1, 32'hA1A1_0001, 4'hF, 1, 32'h14);
      drive(1, 32'h24, 1, 32'hA2A2_0002, 4'hF, 0, 32'h0);
      wait_done();
      chk("arb_order_len", 32'(order_log.size()), 32'd3);
      if (order_log.size() == 3) begin
         chk("arb_first_write", 32'(order_log[0]), 32'd1);
         chk("arb_then_read", 32'(order_log[1]), 32'd2);
         chk("arb_last_write", 32'(order_log[2]), 32'd1);
      end

      // Rejected accesses and the last valid index
      n0 = wr_issues;
      exp_write(32'h8, 32'h5555_5555, 4'h3);
      drive(1, 32'h8, 1, 32'h5555_5555, 4'h3, 0, 32'h0);
      t = aw_hs_cyc;
      wait_done();
      chk("slverr_bvalid_cycle", 32'(b_rise_cyc), 32'(t + 2));
      exp_write(32'h400, 32'h6666_6666, 4'hF);
      drive(1, 32'h400, 1, 32'h6666_6666, 4'hF, 0, 32'h0);
      wait_done();
      exp_read(32'h400);
      drive(0, 32'h0, 0, 32'h0, 4'h0, 1, 32'h400);
      t = ar_hs_cyc;
      wait_done();
      chk("decerr_rvalid_cycle", 32'(r_rise_cyc), 32'(t + 2));
      chk("reject_no_issue", 32'(wr_issues), 32'(n0));
      exp_write(32'h3FC, 32'h0BAD_F00D, 4'hF);
      drive(1, 32'h3FC, 1, 32'h0BAD_F00D, 4'hF, 0, 32'h0);
      wait_done();
      chk("limit_minus_one_issued", 32'(wr_issues), 32'(n0 + 1));

      // W three cycles ahead of AW
      n0 = wr_issues;
      exp_write(32'h30, 32'hCAFE_F00D, 4'hF);
      drive(0, 32'h0, 1, 32'hCAFE_F00D, 4'hF, 0, 32'h0);
      repeat (2) tick();
      chk("w_early_no_issue", 32'(wr_issues), 32'(n0));
      drive(1, 32'h30, 0, 32'h0, 4'h0, 0, 32'h0);
      chk("w_early_gap", 32'(aw_hs_cyc - w_hs_cyc), 32'd3);
      wait_done();
      chk("w_early_issue_cycle", 32'(wr_issue_cyc), 32'(aw_hs_cyc + 2));

      // Reset while in RD_CAPT
      exp_read(32'h10);
      drive(0, 32'h0, 0, 32'h0, 4'h0, 1, 32'h10);
      tick();
      tick();
      chk("rst_rd_in_capt", axi_rd_addr, 32'h4);
      reset = 1'b1;
      tick();
      chk("rst_rd_rvalid", 32'(bus.s_axi_rvalid), 32'h0);
      chk("rst_rd_addr_idle", axi_rd_addr, P_IDLE);
      chk("rst_rd_arready", 32'(bus.s_axi_arready), 32'h0);
      reset = 1'b0;
      exp_r.delete();
      saved = r_rise_cyc;
      repeat (6) tick();
      chk("rst_rd_no_response", 32'(r_rise_cyc), 32'(saved));

      // Reset while in WR_RESP with bready low and a read waiting behind it
      bus.s_axi_bready = 1'b0;
      exp_write(32'h40, 32'h7777_7777, 4'hF);
      drive(1, 32'h40, 1, 32'h7777_7777, 4'hF, 0, 32'h0);
      tick();
      tick();
      chk("rst_wr_bvalid_before", 32'(bus.s_axi_bvalid), 32'h1);
      bus.s_axi_arvalid = 1'b1;
      bus.s_axi_araddr  = 32'h18;
      tick();
      chk("rst_wr_ar_captured", 32'(ar_hs), 32'h1);
      bus.s_axi_arvalid = 1'b0;
      reset = 1'b1;
      tick();
      chk("rst_wr_bvalid", 32'(bus.s_axi_bvalid), 32'h0);
      chk("rst_wr_bresp", 32'(bus.s_axi_bresp), 32'h0);
      chk("rst_wr_addr_idle", axi_wr_addr, P_IDLE);
      chk("rst_wr_rd_idle", axi_rd_addr, P_IDLE);
      reset = 1'b0;
      bus.s_axi_bready = 1'b1;
      exp_b.delete();
      n0 = wr_issues;
      saved = b_rise_cyc;
      repeat (8) tick();
      chk("rst_wr_no_bvalid", 32'(b_rise_cyc), 32'(saved));
      chk("rst_wr_no_reissue", 32'(wr_issues), 32'(n0));

      // Recovery after reset
      exp_write(32'h44, 32'h8888_8888, 4'hF);
      drive(1, 32'h44, 1, 32'h8888_8888, 4'hF, 0, 32'h0);
      exp_read(32'hC);
      drive(0, 32'h0, 0, 32'h0, 4'h0, 1, 32'hC);
      wait_done();
      chk("recover_issue_count", 32'(wr_issues), 32'(n0 + 1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
